memory_stage_unit: RTL

Memory (MEM) stage controller of the 16-bit pipelined CPU, sitting on the consuming side of the EX/MEM pipeline register. It takes that register's outputs, performs loads and stores against a data memory through a request/ready handshake, and stalls the upstream pipeline while an access is outstanding. It emits a registered MEM/WB bundle, inserting a bubble on every stalled cycle so write-back never sees a duplicate instruction.

---
 rtl/memory_stage_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/memory_stage_unit.sv
// memory_stage_unit: MEM stage load/store controller with stall and bubble insertion; access watchdog built when MEM_STAGE_TIMEOUT_EN is defined
module memory_stage_unit #(
  parameter int DATA_W = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wbs_in,
  input  logic              wme_in,
  input  logic              mm_in,
  input  logic [DATA_W-1:0] ALUresult_in,
  input  logic [DATA_W-1:0] memData_in,
  input  logic              wm_in,
  input  logic              ni_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_out,
  output logic              wbs_out,
  output logic              wm_out,
  output logic              ni_out,
  output logic [DATA_W-1:0] ALUresult_out,
  output logic [DATA_W-1:0] memData_out,
  output logic              err_out
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state_q, state_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic wbs_l_q, wbs_l_d, wm_l_q, wm_l_d;
  logic wbs_q, wbs_d, wm_q, wm_d, ni_q, ni_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, alu_q, alu_d, mdata_q, mdata_d;
  logic mem_op, abort, fin;
  assign mem_op = ni_in & (wme_in | mm_in);
`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  assign abort = (state_q == ACCESS) & ~mem_ready & (cnt_q == CW'(TIMEOUT - 1));
  always_comb begin
    cnt_d = (state_q == ACCESS && !mem_ready && !abort) ? cnt_q + 1'b1 : '0;
    err_d = err_q | abort;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err_out = err_q;
`else
  assign abort = 1'b0;
  assign err_out = 1'b0;
`endif
  assign fin = (state_q == ACCESS) & (mem_ready | abort);
  assign stall_out = (state_q == IDLE) ? mem_op : ~fin;
  always_comb begin
    state_d = state_q;
    mem_req_d = mem_req_q;
    mem_we_d = mem_we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wbs_l_d = wbs_l_q;
    wm_l_d = wm_l_q;
    wbs_d = 1'b0;
    wm_d = 1'b0;
    ni_d = 1'b0;
    alu_d = alu_q;
    mdata_d = mdata_q;
    if (state_q == IDLE && mem_op) begin
      state_d = ACCESS;
      mem_req_d = 1'b1;
      mem_we_d = wme_in;
      addr_d = ALUresult_in;
      wdata_d = memData_in;
      wbs_l_d = wbs_in;
      wm_l_d = wm_in;
    end else if (state_q == IDLE) begin
      wbs_d = wbs_in;
      wm_d = wm_in & ni_in;
      ni_d = ni_in;
      alu_d = ALUresult_in;
      mdata_d = '0;
    end else if (fin) begin
      state_d = IDLE;
      mem_req_d = 1'b0;
      wbs_d = wbs_l_q;
      wm_d = wm_l_q & ~abort;
      ni_d = 1'b1;
      alu_d = addr_q;
      mdata_d = (mem_ready && !mem_we_q) ? mem_rdata : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wbs_l_q <= 1'b0;
      wm_l_q <= 1'b0;
      wbs_q <= 1'b0;
      wm_q <= 1'b0;
      ni_q <= 1'b0;
      alu_q <= '0;
      mdata_q <= '0;
    end else begin
      state_q <= state_d;
      mem_req_q <= mem_req_d;
      mem_we_q <= mem_we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wbs_l_q <= wbs_l_d;
      wm_l_q <= wm_l_d;
      wbs_q <= wbs_d;
      wm_q <= wm_d;
      ni_q <= ni_d;
      alu_q <= alu_d;
      mdata_q <= mdata_d;
    end
  end
  assign mem_req = mem_req_q;
  assign mem_we = mem_we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign wbs_out = wbs_q;
  assign wm_out = wm_q;
  assign ni_out = ni_q;
  assign ALUresult_out = alu_q;
  assign memData_out = mdata_q;
endmodule
